branch_hazard_ctrl: RTL and testbench
=====================================

Name: branch_hazard_ctrl

Overview:
- Sequencing controller for ID-stage branch resolution and load-use hazards in the 5-stage MIPS pipeline.
- Decides each cycle whether to freeze PC and IF/ID, insert an ID/EX bubble, select comparator forwarding sources, and flush IF/ID on a taken branch.
- Holds the pending-branch context across stall sequences, bounds stall length with a watchdog, and keeps saturating stall/taken performance counters.

Parameters:
REG_W, 5, register-address width
CNT_W, 16, width of each performance counter
MAX_STALL, 2, maximum legal consecutive stall cycles before hazard_err

Ports:
clock  in  1  system clock, rising edge
resetn  in  1  asynchronous active-low reset
id_valid  in  1  ID holds a real instruction
id_is_branch  in  1  ID instruction is beq/bne
id_branch_ne  in  1  1 = bne, 0 = beq
id_uses_rs, id_uses_rt  in  1 each  ID reads rs / rt
id_rs, id_rt  in  REG_W each  ID source registers
ex_regwrite, ex_memread  in  1 each  ID/EX control
ex_dst  in  REG_W  ID/EX destination
mem_regwrite, mem_memread  in  1 each  EX/MEM control
mem_dst  in  REG_W  EX/MEM destination
wb_regwrite  in  1  MEM/WB write enable
wb_dst  in  REG_W  MEM/WB destination
cmp_equal  in  1  forwarded comparator result (rs==rt)
pc_write  out  1  PC load enable
ifid_write  out  1  IF/ID load enable
idex_bubble  out  1  zero ID/EX control at next edge
ifid_flush  out  1  load a bubble into IF/ID at next edge
branch_taken  out  1  select branch target for PC
cmp_forwarda, cmp_forwardb  out  2 each  00 regfile, 01 EX/MEM, 10 MEM/WB, 11 never driven
hazard_err  out  1  sticky watchdog flag
perf_stalls, perf_taken  out  CNT_W each  saturating counters

Behaviour:
- Reset (async, resetn=0): state=RUN, stall_len=0, pending_branch=0, hazard_err=0, both counters=0. Outputs while in reset: pc_write=1, ifid_write=1, idex_bubble=0, ifid_flush=0, branch_taken=0, forwards=00.
- Match on rs: id_uses_rs && dst!=0 && dst==id_rs. Match on rt is identical. Register 0 never matches.
- Stall condition (combinational, gated by id_valid), evaluated per operand:
  - Branch: stall if ex_regwrite matches, or mem_memread matches.
  - Non-branch: stall if ex_memread matches.
  - stall = OR over both operands.
- Forwarding, per operand:
  - 01 if mem_regwrite && !mem_memread matches.
  - else 10 if wb_regwrite matches.
  - else 00.
  - The EX/MEM match wins over the MEM/WB match. Forward values are driven even during a stall.
- Stall outputs: pc_write = ifid_write = !stall; idex_bubble = stall. All stall outputs are combinational, same cycle.
- branch_taken = id_valid && id_is_branch && !stall && (cmp_equal ^ id_branch_ne).
- ifid_flush = branch_taken. A flush is never asserted during a stall.
- FSM, registered:
  - RUN: on stall, go to STALL; stall_len=1; pending_branch=id_is_branch.
  - STALL, stall still asserted: stall_len++. If stall_len would exceed MAX_STALL, set hazard_err; stall_len saturates.
  - STALL, stall deasserted: go to RUN; stall_len=0. The branch resolves in this same cycle.
  - STALL, id_is_branch != pending_branch: set hazard_err (ID must be frozen).
- Back-to-back case: ALU result in EX then load in MEM is 1 stall each cycle. A load immediately before a branch gives exactly 2 stalls, then MEM/WB forwarding (10).
- Counters:
  - perf_stalls += 1 per stall cycle.
  - perf_taken += 1 per branch_taken cycle.
  - Both saturate at all-ones with no wrap.
- hazard_err is cleared only by reset.
- Reset mid-stall: immediate return to the reset values; no residual pending_branch.

Test Plan:
- ALU-write to r5 in EX, branch in ID using rs=r5 → 1 cycle with pc_write=0, idex_bubble=1. Next cycle cmp_forwarda=01, stall=0, branch resolves; perf_stalls=1.
- lw r7 in EX, beq r7,r3 in ID → 2 stall cycles (EX match, then MEM load match). Third cycle cmp_forwarda=10; with cmp_equal=1 → branch_taken=1, ifid_flush=1, perf_taken=1.
- lw r4 in EX, add using rt=r4 (non-branch) → exactly 1 stall. ALU-write r4 in EX with an add in ID → no stall.
- ex_dst=mem_dst=0 with id_rs=0, both regwrites=1 → no stall, forwards 00. bne with cmp_equal=1 → branch_taken=0.
- Force stall held 3 consecutive cycles → hazard_err=1 after the 3rd, remains 1 after stall clears. Toggle id_is_branch mid-stall → hazard_err=1.
- Deassert resetn during the 2nd stall cycle → outputs return to reset values asynchronously, state=RUN. Preload perf_stalls=all-ones via long run → stays all-ones.

Source files
------------

// File: rtl/branch_hazard_ctrl_if.sv
// rtl/branch_hazard_ctrl_if.sv - pipeline hazard signals between ID/EX/MEM/WB stages and the branch hazard controller
interface branch_hazard_ctrl_if #(
   parameter int REG_W = 5,
   parameter int CNT_W = 16
);
   logic             id_valid;
   logic             id_is_branch;
   logic             id_branch_ne;
   logic             id_uses_rs;
   logic             id_uses_rt;
   logic [REG_W-1:0] id_rs;
   logic [REG_W-1:0] id_rt;
   logic             ex_regwrite;
   logic             ex_memread;
   logic [REG_W-1:0] ex_dst;
   logic             mem_regwrite;
   logic             mem_memread;
   logic [REG_W-1:0] mem_dst;
   logic             wb_regwrite;
   logic [REG_W-1:0] wb_dst;
   logic             cmp_equal;
   logic             pc_write;
   logic             ifid_write;
   logic             idex_bubble;
   logic             ifid_flush;
   logic             branch_taken;
   logic [1:0]       cmp_forwarda;
   logic [1:0]       cmp_forwardb;
   logic             hazard_err;
   logic [CNT_W-1:0] perf_stalls;
   logic [CNT_W-1:0] perf_taken;

   modport master (
      output id_valid, id_is_branch, id_branch_ne, id_uses_rs, id_uses_rt, id_rs, id_rt,
             ex_regwrite, ex_memread, ex_dst, mem_regwrite, mem_memread, mem_dst,
             wb_regwrite, wb_dst, cmp_equal,
      input  pc_write, ifid_write, idex_bubble, ifid_flush, branch_taken,
             cmp_forwarda, cmp_forwardb, hazard_err, perf_stalls, perf_taken
   );

   modport slave (
      input  id_valid, id_is_branch, id_branch_ne, id_uses_rs, id_uses_rt, id_rs, id_rt,
             ex_regwrite, ex_memread, ex_dst, mem_regwrite, mem_memread, mem_dst,
             wb_regwrite, wb_dst, cmp_equal,
      output pc_write, ifid_write, idex_bubble, ifid_flush, branch_taken,
             cmp_forwarda, cmp_forwardb, hazard_err, perf_stalls, perf_taken
   );
endinterface

// File: rtl/branch_hazard_ctrl.sv
// rtl/branch_hazard_ctrl.sv - ID-stage branch resolution and load-use hazard controller
module branch_hazard_ctrl #(
   parameter int REG_W     = 5,
   parameter int CNT_W     = 16,
   parameter int MAX_STALL = 2
) (
   input logic                clock,
   input logic                resetn,
   branch_hazard_ctrl_if.slave bus
);
   localparam int LEN_W = $clog2(MAX_STALL + 1);

   typedef enum logic {RUN, STALL} state_t;

   state_t           state;
   logic [LEN_W-1:0] stall_len;
   logic             pending_branch;
   logic             hazard_err;
   logic [CNT_W-1:0] perf_stalls;
   logic [CNT_W-1:0] perf_taken;

   logic [REG_W-1:0] rs, rt, ex_dst, mem_dst, wb_dst;
   logic             ex_rs, ex_rt, mem_rs, mem_rt, wb_rs, wb_rt;
   logic             stall_rs, stall_rt, stall, taken;

   assign rs      = bus.id_rs;
   assign rt      = bus.id_rt;
   assign ex_dst  = bus.ex_dst;
   assign mem_dst = bus.mem_dst;
   assign wb_dst  = bus.wb_dst;

   // Register 0 is hardwired, so a write to it never creates a dependency.
   function automatic logic reg_hit(input logic uses, input logic [REG_W-1:0] src,
                                    input logic [REG_W-1:0] dst);
      return uses && (dst != '0) && (dst == src);
   endfunction

   assign ex_rs  = reg_hit(bus.id_uses_rs, rs, ex_dst);
   assign ex_rt  = reg_hit(bus.id_uses_rt, rt, ex_dst);
   assign mem_rs = reg_hit(bus.id_uses_rs, rs, mem_dst);
   assign mem_rt = reg_hit(bus.id_uses_rt, rt, mem_dst);
   assign wb_rs  = reg_hit(bus.id_uses_rs, rs, wb_dst);
   assign wb_rt  = reg_hit(bus.id_uses_rt, rt, wb_dst);

   // Branches compare in ID, so they also wait on ALU results in EX and loads in MEM.
   always_comb begin
      stall_rs = 1'b0;
      stall_rt = 1'b0;
      if (bus.id_is_branch) begin
         stall_rs = (bus.ex_regwrite && ex_rs) || (bus.mem_memread && mem_rs);
         stall_rt = (bus.ex_regwrite && ex_rt) || (bus.mem_memread && mem_rt);
      end else begin
         stall_rs = bus.ex_memread && ex_rs;
         stall_rt = bus.ex_memread && ex_rt;
      end
   end

   assign stall = resetn && bus.id_valid && (stall_rs || stall_rt);
   assign taken = resetn && bus.id_valid && bus.id_is_branch && !stall &&
                  (bus.cmp_equal ^ bus.id_branch_ne);

   function automatic logic [1:0] fwd_sel(input logic mem_hit, input logic wb_hit);
      if (bus.mem_regwrite && !bus.mem_memread && mem_hit) return 2'b01;
      if (bus.wb_regwrite && wb_hit)                       return 2'b10;
      return 2'b00;
   endfunction

   assign bus.pc_write     = !stall;
   assign bus.ifid_write   = !stall;
   assign bus.idex_bubble  = stall;
   assign bus.branch_taken = taken;
   assign bus.ifid_flush   = taken;
   assign bus.cmp_forwarda = resetn ? fwd_sel(mem_rs, wb_rs) : 2'b00;
   assign bus.cmp_forwardb = resetn ? fwd_sel(mem_rt, wb_rt) : 2'b00;
   assign bus.hazard_err   = hazard_err;
   assign bus.perf_stalls  = perf_stalls;
   assign bus.perf_taken   = perf_taken;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state          <= RUN;
         stall_len      <= '0;
         pending_branch <= 1'b0;
         hazard_err     <= 1'b0;
         perf_stalls    <= '0;
         perf_taken     <= '0;
      end else begin
         case (state)
            RUN: begin
               if (stall) begin
                  state          <= STALL;
                  stall_len      <= LEN_W'(1);
                  pending_branch <= bus.id_is_branch;
               end
            end
            STALL: begin
               // IF/ID is frozen, so the instruction type must not change mid-stall.
               if (bus.id_is_branch != pending_branch)
                  hazard_err <= 1'b1;
               if (stall) begin
                  if (stall_len == LEN_W'(MAX_STALL))
                     hazard_err <= 1'b1;
                  else
                     stall_len <= stall_len + 1'b1;
               end else begin
                  state     <= RUN;
                  stall_len <= '0;
               end
            end
            default: state <= RUN;
         endcase
         if (stall && (perf_stalls != '1))
            perf_stalls <= perf_stalls + 1'b1;
         if (taken && (perf_taken != '1))
            perf_taken <= perf_taken + 1'b1;
      end
   end
endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// tb/tb_branch_hazard_ctrl.sv - self-checking bench for branch_hazard_ctrl
module tb_branch_hazard_ctrl;
   localparam int REG_W = 5;
   localparam int CNT_W = 8;
   localparam int MAXS  = 2;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic clock = 1'b0;
   logic resetn = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;

   branch_hazard_ctrl_if #(.REG_W(REG_W), .CNT_W(CNT_W)) bif ();

   branch_hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W), .MAX_STALL(MAXS)) dut (
      .clock  (clock),
      .resetn (resetn),
      .bus    (bif.slave)
   );

   always #5 clock = ~clock;

   // Reference model: consecutive-stall run length and saturating event counts.
   int   m_run, m_stalls, m_taken;
   logic m_branch, m_err;

   function automatic logic exp_stall();
      logic s = 1'b0;
      for (int i = 0; i < 2; i++) begin
         logic       u = (i == 0) ? bif.id_uses_rs : bif.id_uses_rt;
         logic [4:0] r = (i == 0) ? bif.id_rs : bif.id_rt;
         if (u && r != 0) begin
            if (bif.id_is_branch)
               s |= (bif.ex_regwrite && bif.ex_dst == r) || (bif.mem_memread && bif.mem_dst == r);
            else
               s |= bif.ex_memread && bif.ex_dst == r;
         end
      end
      return resetn && bif.id_valid && s;
   endfunction

   function automatic logic [1:0] exp_fwd(input logic u, input logic [4:0] r);
      if (!resetn || !u || r == 0) return 2'b00;
      if (bif.mem_regwrite && !bif.mem_memread && bif.mem_dst == r) return 2'b01;
      if (bif.wb_regwrite && bif.wb_dst == r) return 2'b10;
      return 2'b00;
   endfunction

   function automatic logic exp_taken();
      return resetn && bif.id_valid && bif.id_is_branch && !exp_stall() &&
             (bif.cmp_equal != bif.id_branch_ne);
   endfunction

   always @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         m_run = 0; m_branch = 1'b0; m_err = 1'b0; m_stalls = 0; m_taken = 0;
      end else begin
         if (m_run > 0 && bif.id_is_branch != m_branch) m_err = 1'b1;
         if (exp_taken() && m_taken < CMAX) m_taken++;
         if (exp_stall()) begin
            if (m_run == 0) m_branch = bif.id_is_branch;
            m_run++;
            if (m_run > MAXS) m_err = 1'b1;
            if (m_stalls < CMAX) m_stalls++;
         end else begin
            m_run = 0;
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clock) begin
      logic s;
      s = exp_stall();
      chk("pc_write",     bif.pc_write,     !s);
      chk("ifid_write",   bif.ifid_write,   !s);
      chk("idex_bubble",  bif.idex_bubble,  s);
      chk("branch_taken", bif.branch_taken, exp_taken());
      chk("ifid_flush",   bif.ifid_flush,   exp_taken());
      chk("cmp_forwarda", bif.cmp_forwarda, exp_fwd(bif.id_uses_rs, bif.id_rs));
      chk("cmp_forwardb", bif.cmp_forwardb, exp_fwd(bif.id_uses_rt, bif.id_rt));
      chk("hazard_err",   bif.hazard_err,   m_err);
      chk("perf_stalls",  bif.perf_stalls,  m_stalls);
      chk("perf_taken",   bif.perf_taken,   m_taken);
   end

   task automatic idle();
      bif.id_valid = 1'b1; bif.id_is_branch = 1'b0; bif.id_branch_ne = 1'b0;
      bif.id_uses_rs = 1'b0; bif.id_uses_rt = 1'b0; bif.id_rs = '0; bif.id_rt = '0;
      bif.ex_regwrite = 1'b0; bif.ex_memread = 1'b0; bif.ex_dst = '0;
      bif.mem_regwrite = 1'b0; bif.mem_memread = 1'b0; bif.mem_dst = '0;
      bif.wb_regwrite = 1'b0; bif.wb_dst = '0; bif.cmp_equal = 1'b0;
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      idle();
      resetn = 1'b0;
      step();
      resetn = 1'b1;
      #1;
   endtask

   task automatic beq(input logic [4:0] a, input logic [4:0] b);
      bif.id_is_branch = 1'b1; bif.id_uses_rs = 1'b1; bif.id_uses_rt = 1'b1;
      bif.id_rs = a; bif.id_rt = b;
   endtask

   initial begin
      idle();
      #2;
      chk("rst_pc_write", bif.pc_write, 1);
      chk("rst_bubble", bif.idex_bubble, 0);
      chk("rst_fwda", bif.cmp_forwarda, 0);
      do_reset();

      // ALU write r5 in EX, branch on r5
      beq(5'd5, 5'd3); bif.ex_regwrite = 1'b1; bif.ex_dst = 5'd5;
      #1; chk("alu_pc_write", bif.pc_write, 0); chk("alu_bubble", bif.idex_bubble, 1);
      step();
      bif.ex_regwrite = 1'b0; bif.ex_dst = '0; bif.mem_regwrite = 1'b1; bif.mem_dst = 5'd5;
      #1; chk("alu_fwda", bif.cmp_forwarda, 1); chk("alu_nostall", bif.idex_bubble, 0);
      chk("alu_perf_stalls", bif.perf_stalls, 1);
      step();

      // lw r7 then beq r7,r3: two stalls then MEM/WB forward, taken
      do_reset();
      beq(5'd7, 5'd3); bif.ex_regwrite = 1'b1; bif.ex_memread = 1'b1; bif.ex_dst = 5'd7;
      #1; chk("lw_stall1", bif.idex_bubble, 1);
      step();
      bif.ex_regwrite = 1'b0; bif.ex_memread = 1'b0; bif.ex_dst = '0;
      bif.mem_regwrite = 1'b1; bif.mem_memread = 1'b1; bif.mem_dst = 5'd7;
      #1; chk("lw_stall2", bif.idex_bubble, 1);
      step();
      bif.mem_regwrite = 1'b0; bif.mem_memread = 1'b0; bif.mem_dst = '0;
      bif.wb_regwrite = 1'b1; bif.wb_dst = 5'd7; bif.cmp_equal = 1'b1;
      #1; chk("lw_fwda", bif.cmp_forwarda, 2); chk("lw_taken", bif.branch_taken, 1);
      chk("lw_flush", bif.ifid_flush, 1);
      step();
      chk("lw_perf_taken", bif.perf_taken, 1); chk("lw_perf_stalls", bif.perf_stalls, 2);
      chk("lw_err", bif.hazard_err, 0);

      // load-use on a non-branch: one stall only; ALU result never stalls a non-branch
      do_reset();
      bif.id_uses_rt = 1'b1; bif.id_rt = 5'd4;
      bif.ex_regwrite = 1'b1; bif.ex_memread = 1'b1; bif.ex_dst = 5'd4;
      #1; chk("ld_use_stall", bif.idex_bubble, 1);
      step();
      bif.ex_regwrite = 1'b0; bif.ex_memread = 1'b0; bif.ex_dst = '0;
      bif.mem_regwrite = 1'b1; bif.mem_memread = 1'b1; bif.mem_dst = 5'd4;
      #1; chk("ld_use_done", bif.idex_bubble, 0);
      step();
      idle(); bif.id_uses_rt = 1'b1; bif.id_rt = 5'd4; bif.ex_regwrite = 1'b1; bif.ex_dst = 5'd4;
      #1; chk("alu_add_nostall", bif.pc_write, 1);
      step();

      // register 0 never matches; bne with equal operands not taken
      idle(); beq(5'd0, 5'd0); bif.id_branch_ne = 1'b1; bif.cmp_equal = 1'b1;
      bif.ex_regwrite = 1'b1; bif.mem_regwrite = 1'b1; bif.wb_regwrite = 1'b1;
      #1; chk("r0_nostall", bif.idex_bubble, 0); chk("r0_fwda", bif.cmp_forwarda, 0);
      chk("bne_eq_taken", bif.branch_taken, 0);
      step();

      // watchdog: three consecutive stall cycles
      do_reset();
      beq(5'd5, 5'd0); bif.id_uses_rt = 1'b0; bif.ex_regwrite = 1'b1; bif.ex_dst = 5'd5;
      step(); step();
      chk("wd_err_after2", bif.hazard_err, 0);
      step();
      chk("wd_err_after3", bif.hazard_err, 1);
      idle(); step();
      chk("wd_err_sticky", bif.hazard_err, 1);

      // instruction type changes while frozen
      do_reset();
      beq(5'd5, 5'd0); bif.id_uses_rt = 1'b0; bif.ex_regwrite = 1'b1; bif.ex_dst = 5'd5;
      step();
      bif.id_is_branch = 1'b0;
      step();
      chk("toggle_err", bif.hazard_err, 1);

      // async reset during the 2nd stall cycle
      do_reset();
      beq(5'd7, 5'd3); bif.ex_regwrite = 1'b1; bif.ex_memread = 1'b1; bif.ex_dst = 5'd7;
      step();
      bif.ex_regwrite = 1'b0; bif.ex_memread = 1'b0; bif.ex_dst = '0;
      bif.mem_memread = 1'b1; bif.mem_regwrite = 1'b1; bif.mem_dst = 5'd7;
      #1; resetn = 1'b0; #1;
      chk("mid_rst_pc_write", bif.pc_write, 1); chk("mid_rst_bubble", bif.idex_bubble, 0);
      chk("mid_rst_stalls", bif.perf_stalls, 0);
      step();
      idle(); resetn = 1'b1; step();
      chk("post_rst_err", bif.hazard_err, 0);

      // saturation of perf_stalls
      do_reset();
      bif.id_uses_rs = 1'b1; bif.id_rs = 5'd9; bif.ex_memread = 1'b1; bif.ex_dst = 5'd9;
      for (int i = 0; i < CMAX + 20; i++) step();
      chk("sat_stalls", bif.perf_stalls, CMAX);
      idle(); step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
